alu_res_station: RTL and testbench
==================================

ALU_RES_STATION -- requirements
Module: alu_res_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries, 2..8.
REQ-002 SHALL have parameter TAGW, default 6: ROB tag width.
REQ-003 SHALL have ports `clk` (input, 1, rising-edge clock) and `rst_n` (input, 1, asynchronous active-low reset), listed first.
REQ-004 SHALL have port `flush` (input, 1): synchronous clear of all entries and the issue register.
REQ-005 SHALL have port `dp_valid` (input, 1): dispatch request.
REQ-006 SHALL have port `dp_ready` (output, 1): entry available.
REQ-007 SHALL have ports `dp_rs_rdy` and `dp_rt_rdy` (input, 1 each): operand already valid.
REQ-008 SHALL have ports `dp_rs_tag` and `dp_rt_tag` (input, TAGW each): producer tag of a pending operand.
REQ-009 SHALL have ports `dp_rs_val` and `dp_rt_val` (input, 32 each): operand value when its rdy bit is 1.
REQ-010 SHALL have ports `dp_dst_tag` (input, TAGW, result tag), `dp_instr` (input, 32, instruction word) and `dp_pc_1` (input, 32, PC+1).
REQ-011 SHALL have port `dp_ctrl` (input, 9): {ldic, isSignEx, immed, alu_ctrl3..0, isJump, isJR}.
REQ-012 SHALL have ports `cdb_valid` (input, 1), `cdb_tag` (input, TAGW) and `cdb_data` (input, 32): result broadcast.
REQ-013 SHALL have ports `iss_valid` (output, 1) and `iss_stall` (input, 1): issue handshake; EX consumes when iss_valid=1 and iss_stall=0.
REQ-014 SHALL have ports `iss_rs_data`, `iss_rt_data`, `iss_pc_1`, `iss_instr` (output, 32 each), `iss_ctrl` (output, 9) and `iss_dst_tag` (output, TAGW): the registered issued entry.

Function
REQ-015 Entries SHALL be kept age-ordered: index 0 is oldest and valid entries are contiguous from 0.
REQ-016 Dispatch SHALL be accepted when dp_valid=1, dp_ready=1 and flush=0; the new entry is written at index = current count (after collapse, if an issue occurs in the same cycle).
REQ-017 dp_ready SHALL be 1 iff the registered count < DEPTH; a full station SHALL NOT accept dispatch even in an issue cycle.
REQ-018 Dispatch bypass: if an operand's rdy bit is 0 and cdb_valid=1 with cdb_tag equal to its tag in the same cycle, the entry SHALL store cdb_data with rdy=1.
REQ-019 Wakeup: each valid entry with a pending operand whose tag matches a valid CDB SHALL capture cdb_data and set rdy at that edge; both operands may wake on one broadcast.
REQ-020 Select: the lowest-index valid entry with both rdy bits set (registered state only) SHALL be chosen.
REQ-021 The issue register SHALL load the selected entry when it is empty or is being consumed; the selected entry SHALL be removed and higher entries SHALL shift down one index in the same edge.
REQ-022 When iss_valid=1 and iss_stall=1, all iss_* outputs SHALL hold and no entry SHALL be removed.
REQ-023 Latency: dispatch with both operands ready in cycle N SHALL give iss_valid in N+2 when the station is otherwise idle; a CDB wakeup in N SHALL give issue outputs in N+2.
REQ-024 A wakeup and a shift in the same edge SHALL both apply, i.e. the shifted entry carries the captured value.
REQ-025 flush=1 SHALL clear count, all valid bits and iss_valid at the next edge; dispatch, wakeup and issue that cycle SHALL be ignored.
REQ-026 A CDB tag matching no pending operand SHALL have no effect; a match on an invalid entry SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force count=0, all valid bits=0, iss_valid=0 and dp_ready=1, and zero all iss_* data outputs.
REQ-028 Reset asserted mid-operation SHALL discard all entries with no partial issue; after release the station SHALL behave as empty.

Verification
REQ-029 Both operands ready: dispatch rs=5, rt=7, dst=3 in cycle 1 -> iss_valid=1 in cycle 3 with iss_rs_data=5, iss_rt_data=7, iss_dst_tag=3.
REQ-030 Wakeup: dispatch with rt pending on tag 9, then CDB tag 9 data 0x1234 in cycle 4 -> iss_rt_data=0x1234, iss_valid=1 in cycle 6.
REQ-031 Ordering: dispatch A (pending), then B and C (ready) -> B issues before C; after A wakes it issues after C only if C is already latched, else before C.
REQ-032 Full: dispatch 4 entries all pending -> dp_ready=0; a 5th dp_valid is ignored; one wakeup plus issue -> dp_ready=1 the following cycle.
REQ-033 Stall: iss_stall=1 for 3 cycles with valid output -> outputs stable and count unchanged; consumed on the first cycle with stall=0.
REQ-034 Flush and reset: 3 entries plus a valid issue, pulse flush -> next cycle iss_valid=0 and dp_ready=1; repeat with rst_n=0 -> same result asynchronously.

Source files
------------

// File: rtl/alu_res_station.sv
// ----------------------------------------------------------------------------
// alu_res_station
//
// Age-ordered reservation station for the ALU. It holds up to DEPTH
// dispatched instructions, captures missing operands from the result
// broadcast bus (CDB), and feeds the oldest fully-ready entry into a
// registered issue slot that the execute stage drains.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   flush                 synchronous clear of all entries and the issue slot
//   dp_valid / dp_ready   dispatch handshake (dp_ready = an entry is free)
//   dp_rs_* / dp_rt_*     operand ready bit, producer tag and value
//   dp_dst_tag            ROB tag of the result
//   dp_instr, dp_pc_1     instruction word and PC+1, carried to issue
//   dp_ctrl               {ldic, isSignEx, immed, alu_ctrl[3:0], isJump, isJR}
//   cdb_valid/tag/data    result broadcast used for operand wakeup
//   iss_valid / iss_stall issue handshake; consumed when valid and not stalled
//   iss_*                 registered contents of the issued entry
// ----------------------------------------------------------------------------
module alu_res_station #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            dp_valid,
    output logic            dp_ready,
    input  logic            dp_rs_rdy,
    input  logic            dp_rt_rdy,
    input  logic [TAGW-1:0] dp_rs_tag,
    input  logic [TAGW-1:0] dp_rt_tag,
    input  logic [31:0]     dp_rs_val,
    input  logic [31:0]     dp_rt_val,
    input  logic [TAGW-1:0] dp_dst_tag,
    input  logic [31:0]     dp_instr,
    input  logic [31:0]     dp_pc_1,
    input  logic [8:0]      dp_ctrl,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    output logic            iss_valid,
    input  logic            iss_stall,
    output logic [31:0]     iss_rs_data,
    output logic [31:0]     iss_rt_data,
    output logic [31:0]     iss_pc_1,
    output logic [31:0]     iss_instr,
    output logic [8:0]      iss_ctrl,
    output logic [TAGW-1:0] iss_dst_tag
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            rs_rdy;
        logic            rt_rdy;
        logic [TAGW-1:0] rs_tag;
        logic [TAGW-1:0] rt_tag;
        logic [31:0]     rs_val;
        logic [31:0]     rt_val;
        logic [TAGW-1:0] dst_tag;
        logic [31:0]     instr;
        logic [31:0]     pc_1;
        logic [8:0]      ctrl;
    } entry_t;

    // Registered station state
    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    count_q;

    // Next-state
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    count_d;

    // Entries after wakeup, extended by one empty slot so the shift can read
    // index i+1 uniformly.
    entry_t           woken [DEPTH+1];
    logic [DEPTH:0]   vld_ext;

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             iss_load;
    logic             iss_take;
    logic             dp_accept;
    entry_t           dp_entry;

    assign dp_ready  = (count_q < CW'(DEPTH));
    assign dp_accept = dp_valid && dp_ready && !flush;
    assign iss_take  = iss_valid && !iss_stall;
    // The slot can accept a new entry when it is empty or drains this edge.
    assign iss_load  = sel_found && (!iss_valid || !iss_stall) && !flush;

    // Oldest ready entry, from registered state only. Scanning from the top
    // down lets the lowest index overwrite any higher match.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && ent_q[i].rs_rdy && ent_q[i].rt_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // New entry, with same-cycle CDB bypass for pending operands.
    always_comb begin
        dp_entry.rs_rdy  = dp_rs_rdy;
        dp_entry.rt_rdy  = dp_rt_rdy;
        dp_entry.rs_tag  = dp_rs_tag;
        dp_entry.rt_tag  = dp_rt_tag;
        dp_entry.rs_val  = dp_rs_val;
        dp_entry.rt_val  = dp_rt_val;
        dp_entry.dst_tag = dp_dst_tag;
        dp_entry.instr   = dp_instr;
        dp_entry.pc_1    = dp_pc_1;
        dp_entry.ctrl    = dp_ctrl;
        if (!dp_rs_rdy && cdb_valid && (cdb_tag == dp_rs_tag)) begin
            dp_entry.rs_rdy = 1'b1;
            dp_entry.rs_val = cdb_data;
        end
        if (!dp_rt_rdy && cdb_valid && (cdb_tag == dp_rt_tag)) begin
            dp_entry.rt_rdy = 1'b1;
            dp_entry.rt_val = cdb_data;
        end
    end

    // Wakeup, then collapse over the issued entry, then append the dispatch.
    // Doing the wakeup first means a shifted entry carries the captured value.
    always_comb begin
        // NOTE: blocking assignments here build the next-state in stages;
        // the flops below are the only place state is updated, with <=.
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            if (vld_q[i] && cdb_valid) begin
                if (!ent_q[i].rs_rdy && (ent_q[i].rs_tag == cdb_tag)) begin
                    woken[i].rs_rdy = 1'b1;
                    woken[i].rs_val = cdb_data;
                end
                if (!ent_q[i].rt_rdy && (ent_q[i].rt_tag == cdb_tag)) begin
                    woken[i].rt_rdy = 1'b1;
                    woken[i].rt_val = cdb_data;
                end
            end
        end
        woken[DEPTH] = '0;
        vld_ext      = {1'b0, vld_q};

        count_d = count_q;
        vld_d   = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woken[i];
        end

        if (iss_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = woken[i+1];
                    vld_d[i] = vld_ext[i+1];
                end
            end
            count_d = count_q - CW'(1);
        end

        if (dp_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_d) begin
                    ent_d[i] = dp_entry;
                    vld_d[i] = 1'b1;
                end
            end
            count_d = count_d + CW'(1);
        end

        if (flush) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry payload has no reset; its valid bit gates every use, so
    // resetting the wide storage would only cost reset routing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    // Issue slot. Holds while stalled; clears when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid   <= 1'b0;
            iss_rs_data <= '0;
            iss_rt_data <= '0;
            iss_pc_1    <= '0;
            iss_instr   <= '0;
            iss_ctrl    <= '0;
            iss_dst_tag <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (iss_load) begin
            iss_valid   <= 1'b1;
            iss_rs_data <= ent_q[sel_idx].rs_val;
            iss_rt_data <= ent_q[sel_idx].rt_val;
            iss_pc_1    <= ent_q[sel_idx].pc_1;
            iss_instr   <= ent_q[sel_idx].instr;
            iss_ctrl    <= ent_q[sel_idx].ctrl;
            iss_dst_tag <= ent_q[sel_idx].dst_tag;
        end else if (iss_take) begin
            iss_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_res_station.sv
// ----------------------------------------------------------------------------
// tb_alu_res_station
//
// Scoreboarded bench for alu_res_station. Dispatches push their expected
// issue record; a monitor pops and compares whenever the issue slot is
// drained. Scenario tasks add inline timing and handshake checks.
// ----------------------------------------------------------------------------
module tb_alu_res_station;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dp_valid;
    logic        dp_ready;
    logic        dp_rs_rdy;
    logic        dp_rt_rdy;
    logic [5:0]  dp_rs_tag;
    logic [5:0]  dp_rt_tag;
    logic [31:0] dp_rs_val;
    logic [31:0] dp_rt_val;
    logic [5:0]  dp_dst_tag;
    logic [31:0] dp_instr;
    logic [31:0] dp_pc_1;
    logic [8:0]  dp_ctrl;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid;
    logic        iss_stall;
    logic [31:0] iss_rs_data;
    logic [31:0] iss_rt_data;
    logic [31:0] iss_pc_1;
    logic [31:0] iss_instr;
    logic [8:0]  iss_ctrl;
    logic [5:0]  iss_dst_tag;

    alu_res_station #(.DEPTH(4), .TAGW(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_rs_rdy   (dp_rs_rdy),
        .dp_rt_rdy   (dp_rt_rdy),
        .dp_rs_tag   (dp_rs_tag),
        .dp_rt_tag   (dp_rt_tag),
        .dp_rs_val   (dp_rs_val),
        .dp_rt_val   (dp_rt_val),
        .dp_dst_tag  (dp_dst_tag),
        .dp_instr    (dp_instr),
        .dp_pc_1     (dp_pc_1),
        .dp_ctrl     (dp_ctrl),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .iss_valid   (iss_valid),
        .iss_stall   (iss_stall),
        .iss_rs_data (iss_rs_data),
        .iss_rt_data (iss_rt_data),
        .iss_pc_1    (iss_pc_1),
        .iss_instr   (iss_instr),
        .iss_ctrl    (iss_ctrl),
        .iss_dst_tag (iss_dst_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  dst;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Side fields are derived from the destination tag so every issued
    // record has distinct instr / pc / ctrl values.
    function automatic logic [31:0] instr_of(input logic [5:0] dst);
        return 32'hA000_0000 | {26'd0, dst};
    endfunction
    function automatic logic [31:0] pc_of(input logic [5:0] dst);
        return 32'h0000_0100 + {26'd0, dst};
    endfunction
    function automatic logic [8:0] ctrl_of(input logic [5:0] dst);
        return {3'b101, dst};
    endfunction

    // Scoreboard monitor: the slot is drained at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && iss_valid && !iss_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got dst=%0d rs=%h rt=%h, expected no issue",
                         iss_dst_tag, iss_rs_data, iss_rt_data);
            end else begin
                mon_e = sb.pop_front();
                if (iss_rs_data !== mon_e.rs || iss_rt_data !== mon_e.rt ||
                    iss_dst_tag !== mon_e.dst || iss_instr !== instr_of(mon_e.dst) ||
                    iss_pc_1 !== pc_of(mon_e.dst) || iss_ctrl !== ctrl_of(mon_e.dst)) begin
                    errors++;
                    $display("FAIL issue_record got dst=%0d rs=%h rt=%h instr=%h pc=%h ctrl=%h, expected dst=%0d rs=%h rt=%h instr=%h pc=%h ctrl=%h",
                             iss_dst_tag, iss_rs_data, iss_rt_data, iss_instr, iss_pc_1, iss_ctrl,
                             mon_e.dst, mon_e.rs, mon_e.rt, instr_of(mon_e.dst),
                             pc_of(mon_e.dst), ctrl_of(mon_e.dst));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one dispatch cycle; returns 1 time unit after the capturing edge.
    task automatic dispatch_cycle(input logic rs_rdy, input logic [5:0] rs_tag,
                                  input logic [31:0] rs_val, input logic rt_rdy,
                                  input logic [5:0] rt_tag, input logic [31:0] rt_val,
                                  input logic [5:0] dst);
        dp_valid   = 1'b1;
        dp_rs_rdy  = rs_rdy;
        dp_rs_tag  = rs_tag;
        dp_rs_val  = rs_val;
        dp_rt_rdy  = rt_rdy;
        dp_rt_tag  = rt_tag;
        dp_rt_val  = rt_val;
        dp_dst_tag = dst;
        dp_instr   = instr_of(dst);
        dp_pc_1    = pc_of(dst);
        dp_ctrl    = ctrl_of(dst);
        tick();
        dp_valid   = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (iss_valid !== 1'b0 || dp_ready !== 1'b1 || iss_rs_data !== 32'd0 ||
            iss_rt_data !== 32'd0 || iss_dst_tag !== 6'd0) begin
            errors++;
            $display("FAIL reset_state got iss_valid=%b dp_ready=%b rs=%h rt=%h dst=%0d, expected 0 1 0 0 0",
                     iss_valid, dp_ready, iss_rs_data, iss_rt_data, iss_dst_tag);
        end
        ticks(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (iss_valid !== 1'b0 || dp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got iss_valid=%b dp_ready=%b, expected 0 1",
                     iss_valid, dp_ready);
        end
    endtask

    task automatic test_both_ready();
        sb.push_back('{32'd5, 32'd7, 6'd3});
        dispatch_cycle(1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3);
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_latency_n1 got iss_valid=%b, expected 0", iss_valid);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_rs_data !== 32'd5 || iss_rt_data !== 32'd7 ||
            iss_dst_tag !== 6'd3) begin
            errors++;
            $display("FAIL ready_latency_n2 got valid=%b rs=%h rt=%h dst=%0d, expected 1 5 7 3",
                     iss_valid, iss_rs_data, iss_rt_data, iss_dst_tag);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_drained got iss_valid=%b, expected 0", iss_valid);
        end
        tick();
    endtask

    task automatic test_wakeup();
        // Single pending operand, with an unrelated broadcast first.
        sb.push_back('{32'h11, 32'h1234, 6'd4});
        dispatch_cycle(1'b1, 6'd0, 32'h11, 1'b0, 6'd9, 32'd0, 6'd4);
        cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'hDEAD;
        tick();
        cdb_valid = 1'b0;
        tick();
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_nomatch got iss_valid=%b, expected 0", iss_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h1234;
        tick();
        cdb_valid = 1'b0;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_latency_n1 got iss_valid=%b, expected 0", iss_valid);
        end
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_rt_data !== 32'h1234) begin
            errors++;
            $display("FAIL wake_latency_n2 got valid=%b rt=%h, expected 1 00001234",
                     iss_valid, iss_rt_data);
        end
        tick();

        // Both operands on one broadcast.
        sb.push_back('{32'h55, 32'h55, 6'd5});
        dispatch_cycle(1'b0, 6'd15, 32'd0, 1'b0, 6'd15, 32'd0, 6'd5);
        cdb_valid = 1'b1; cdb_tag = 6'd15; cdb_data = 32'h55;
        tick();
        cdb_valid = 1'b0;
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_rs_data !== 32'h55 || iss_rt_data !== 32'h55) begin
            errors++;
            $display("FAIL wake_both got valid=%b rs=%h rt=%h, expected 1 55 55",
                     iss_valid, iss_rs_data, iss_rt_data);
        end
        tick();

        // Dispatch-cycle bypass.
        sb.push_back('{32'h21, 32'hBEEF, 6'd6});
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hBEEF;
        dispatch_cycle(1'b1, 6'd0, 32'h21, 1'b0, 6'd12, 32'd0, 6'd6);
        cdb_valid = 1'b0;
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_rt_data !== 32'hBEEF) begin
            errors++;
            $display("FAIL bypass got valid=%b rt=%h, expected 1 0000beef",
                     iss_valid, iss_rt_data);
        end
        tick();
    endtask

    task automatic test_order();
        // A pending, B and C ready, slot free-running: B, C, then A.
        sb.push_back('{32'd1, 32'd2, 6'd11});
        sb.push_back('{32'd3, 32'd4, 6'd12});
        dispatch_cycle(1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'h9, 6'd10);
        dispatch_cycle(1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 6'd11);
        dispatch_cycle(1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4, 6'd12);
        ticks(4);
        sb.push_back('{32'h77, 32'h9, 6'd10});
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h77;
        tick();
        cdb_valid = 1'b0;
        ticks(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL order1_drained got %0d pending, expected 0", sb.size());
        end

        // Same shape with B held in the slot: A wakes and overtakes C.
        iss_stall = 1'b1;
        sb.push_back('{32'd5, 32'd6, 6'd14});
        sb.push_back('{32'h66, 32'h8, 6'd13});
        sb.push_back('{32'd7, 32'd8, 6'd15});
        dispatch_cycle(1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'h8, 6'd13);
        dispatch_cycle(1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6, 6'd14);
        dispatch_cycle(1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8, 6'd15);
        checks++;
        if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd14) begin
            errors++;
            $display("FAIL order2_b_latched got valid=%b dst=%0d, expected 1 14",
                     iss_valid, iss_dst_tag);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd21; cdb_data = 32'h66;
        tick();
        cdb_valid = 1'b0;
        iss_stall = 1'b0;
        tick();
        checks++;
        if (iss_dst_tag !== 6'd13) begin
            errors++;
            $display("FAIL order2_a_before_c got dst=%0d, expected 13", iss_dst_tag);
        end
        ticks(3);
    endtask

    task automatic test_full();
        sb.push_back('{32'hB1, 32'hA1, 6'd41});
        sb.push_back('{32'hB2, 32'hA2, 6'd42});
        sb.push_back('{32'hB3, 32'hA3, 6'd43});
        sb.push_back('{32'hB0, 32'hA0, 6'd40});
        dispatch_cycle(1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'hA0, 6'd40);
        dispatch_cycle(1'b0, 6'd31, 32'd0, 1'b1, 6'd0, 32'hA1, 6'd41);
        dispatch_cycle(1'b0, 6'd32, 32'd0, 1'b1, 6'd0, 32'hA2, 6'd42);
        dispatch_cycle(1'b0, 6'd33, 32'd0, 1'b1, 6'd0, 32'hA3, 6'd43);
        checks++;
        if (dp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got dp_ready=%b, expected 0", dp_ready);
        end
        // Fifth dispatch must be dropped.
        dispatch_cycle(1'b1, 6'd0, 32'hE, 1'b1, 6'd0, 32'hF, 6'd44);
        tick();
        checks++;
        if (dp_ready !== 1'b0 || iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_ignored got dp_ready=%b iss_valid=%b, expected 0 0",
                     dp_ready, iss_valid);
        end
        // Wake entry 41; next cycle it issues while entry 42 wakes during the
        // shift and a dispatch is attempted on the still-full station.
        cdb_valid = 1'b1; cdb_tag = 6'd31; cdb_data = 32'hB1;
        tick();
        cdb_tag = 6'd32; cdb_data = 32'hB2;
        dp_valid = 1'b1; dp_rs_rdy = 1'b1; dp_rt_rdy = 1'b1; dp_dst_tag = 6'd45;
        dp_rs_val = 32'h45; dp_rt_val = 32'h45;
        dp_instr = instr_of(6'd45); dp_pc_1 = pc_of(6'd45); dp_ctrl = ctrl_of(6'd45);
        checks++;
        if (dp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_issue_cycle got dp_ready=%b, expected 0", dp_ready);
        end
        tick();
        dp_valid  = 1'b0;
        cdb_valid = 1'b0;
        checks++;
        if (dp_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_after_issue got dp_ready=%b, expected 1", dp_ready);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd33; cdb_data = 32'hB3;
        tick();
        cdb_valid = 1'b0;
        ticks(2);
        cdb_valid = 1'b1; cdb_tag = 6'd30; cdb_data = 32'hB0;
        tick();
        cdb_valid = 1'b0;
        ticks(3);
        checks++;
        if (sb.size() != 0 || dp_ready !== 1'b1 || iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drained got pending=%0d dp_ready=%b iss_valid=%b, expected 0 1 0",
                     sb.size(), dp_ready, iss_valid);
        end
    endtask

    task automatic test_stall();
        iss_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{32'h500 + 32'(i), 32'h600 + 32'(i), 6'(50 + i)});
            dispatch_cycle(1'b1, 6'd0, 32'h500 + 32'(i), 1'b1, 6'd0,
                           32'h600 + 32'(i), 6'(50 + i));
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd50 || iss_rs_data !== 32'h500 ||
                iss_rt_data !== 32'h600 || dp_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b dst=%0d rs=%h rt=%h dp_ready=%b, expected 1 50 500 600 0",
                         c, iss_valid, iss_dst_tag, iss_rs_data, iss_rt_data, dp_ready);
            end
            tick();
        end
        iss_stall = 1'b0;
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd51 || dp_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got valid=%b dst=%0d dp_ready=%b, expected 1 51 1",
                     iss_valid, iss_dst_tag, dp_ready);
        end
        ticks(5);
    endtask

    task automatic test_flush();
        iss_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            dispatch_cycle(1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i), 6'(60 + i));
        checks++;
        if (iss_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got iss_valid=%b, expected 1", iss_valid);
        end
        // Dispatch and wakeup in the flush cycle must be dropped too.
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd1; cdb_data = 32'h1;
        dp_valid = 1'b1; dp_rs_rdy = 1'b1; dp_rt_rdy = 1'b1; dp_dst_tag = 6'd0;
        tick();
        flush = 1'b0; dp_valid = 1'b0; cdb_valid = 1'b0;
        checks++;
        if (iss_valid !== 1'b0 || dp_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got iss_valid=%b dp_ready=%b, expected 0 1",
                     iss_valid, dp_ready);
        end
        iss_stall = 1'b0;
        ticks(4);
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty got iss_valid=%b, expected 0", iss_valid);
        end
    endtask

    task automatic test_reset_mid();
        iss_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            dispatch_cycle(1'b1, 6'd0, 32'h70 + 32'(i), 1'b1, 6'd0, 32'h70, 6'(20 + i));
        checks++;
        if (iss_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got iss_valid=%b, expected 1", iss_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (iss_valid !== 1'b0 || dp_ready !== 1'b1 || iss_rs_data !== 32'd0 ||
            iss_dst_tag !== 6'd0) begin
            errors++;
            $display("FAIL rst_async got valid=%b dp_ready=%b rs=%h dst=%0d, expected 0 1 0 0",
                     iss_valid, dp_ready, iss_rs_data, iss_dst_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        iss_stall = 1'b0;
        ticks(4);
        checks++;
        if (iss_valid !== 1'b0 || dp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_empty got iss_valid=%b dp_ready=%b, expected 0 1",
                     iss_valid, dp_ready);
        end
        sb.push_back('{32'h81, 32'h82, 6'd7});
        dispatch_cycle(1'b1, 6'd0, 32'h81, 1'b1, 6'd0, 32'h82, 6'd7);
        tick();
        checks++;
        if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd7) begin
            errors++;
            $display("FAIL rst_after_use got valid=%b dst=%0d, expected 1 7",
                     iss_valid, iss_dst_tag);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0; dp_valid = 1'b0; dp_rs_rdy = 1'b0; dp_rt_rdy = 1'b0;
        dp_rs_tag = '0; dp_rt_tag = '0; dp_rs_val = '0; dp_rt_val = '0;
        dp_dst_tag = '0; dp_instr = '0; dp_pc_1 = '0; dp_ctrl = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; iss_stall = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        test_reset();
        test_both_ready();
        test_wakeup();
        test_order();
        test_full();
        test_stall();
        test_flush();
        test_reset_mid();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
